logical_tile_io_array_cfg: RTL and testbench

//  Parametrised multi-channel embedded-IO logical tile: NUM_IO pads, each runtime-configurable as

---
 rtl/logical_tile_io_array_cfg_pkg.sv | 14 +
 rtl/logical_tile_io_array_cfg_if.sv | 27 ++
 rtl/logical_tile_io_array_cfg_io_cfg_chain.sv | 71 +++++++
 rtl/logical_tile_io_array_cfg.sv | 83 ++++++++
 tb/tb_logical_tile_io_array_cfg.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/logical_tile_io_array_cfg_pkg.sv
// Shared constants and FSM state type for the embedded-IO logical tile.
// Optional feature macro used by the tile: IO_INPUT_SYNC_EN.
package io_tile_pkg;
  localparam int CFG_W    = 3;
  localparam int CFG_DIR  = 0;
  localparam int CFG_IREG = 1;
  localparam int CFG_OREG = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;
endpackage

// File: rtl/logical_tile_io_array_cfg_if.sv
// Pad-side and fabric-side data bundle of the IO tile.
// No valid/ready: every signal is a level, sampled or driven on each prog_clk cycle.
interface logical_tile_io_array_cfg_if #(
  parameter int NUM_IO = 4
);
  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN;
  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT;
  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR;
  logic [NUM_IO-1:0] io_outpad;
  logic [NUM_IO-1:0] io_inpad;

  modport master (
    output gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN,
    output io_outpad,
    input  gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT,
    input  gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR,
    input  io_inpad
  );

  modport slave (
    input  gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN,
    input  io_outpad,
    output gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT,
    output gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR,
    output io_inpad
  );
endinterface

// File: rtl/logical_tile_io_array_cfg_io_cfg_chain.sv
// Config shift chain with shadow register, bit counter and commit FSM.
// Active config only moves in COMMIT, after a load of exactly CHAIN_LEN bits.
module io_cfg_chain
  import io_tile_pkg::*;
#(
  parameter int CHAIN_LEN = 12
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset,
  input  logic                 ccff_head,
  input  logic                 ccff_shift_en,
  output logic                 ccff_tail,
  output logic [CHAIN_LEN-1:0] active_cfg,
  output logic                 cfg_valid,
  output logic                 cfg_err,
  output cfg_state_t           cfg_state
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] shadow;
  logic [CNT_W-1:0]     cnt;

  // The shadow MSB is itself a flop, so the serial output needs no extra stage.
  assign ccff_tail = shadow[CHAIN_LEN-1];

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      shadow     <= '0;
      active_cfg <= '0;
      cnt        <= '0;
      cfg_valid  <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_state  <= IDLE;
    end else begin
      if (ccff_shift_en) shadow <= {shadow[CHAIN_LEN-2:0], ccff_head};
      unique case (cfg_state)
        IDLE: begin
          if (ccff_shift_en) begin
            cnt       <= CNT_W'(1);
            cfg_err   <= 1'b0;
            cfg_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ccff_shift_en) begin
            if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
          end else if (cnt == CNT_FULL) begin
            cfg_state <= COMMIT;
          end else begin
            cfg_err   <= 1'b1;
            cfg_state <= IDLE;
          end
        end
        COMMIT: begin
          // Non-blocking read captures the shadow before any shift this cycle.
          active_cfg <= shadow;
          cfg_valid  <= 1'b1;
          if (ccff_shift_en) begin
            cnt       <= CNT_W'(1);
            cfg_state <= SHIFT;
          end else begin
            cfg_state <= IDLE;
          end
        end
        default: cfg_state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/logical_tile_io_array_cfg.sv
// Multi-channel embedded-IO logical tile: per-pad direction and optional in/out registration.
// Define IO_INPUT_SYNC_EN to add a 2-flop synchroniser on every pad input.
module logical_tile_io_array_cfg
  import io_tile_pkg::*;
#(
  parameter int NUM_IO = 4
) (
  input  logic       prog_clk,
  input  logic       prog_reset,
  input  logic       IO_ISOL_N,
  input  logic       ccff_head,
  input  logic       ccff_shift_en,
  output logic       ccff_tail,
  output logic       cfg_valid,
  output logic       cfg_err,
  output cfg_state_t cfg_state,
  logical_tile_io_array_cfg_if.slave io
);
  localparam int CHAIN_LEN = NUM_IO * CFG_W;

  logic [CHAIN_LEN-1:0] active_cfg;
  logic [NUM_IO-1:0]    dir_v, out_v, in_v;

  io_cfg_chain #(.CHAIN_LEN(CHAIN_LEN)) u_chain (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .active_cfg    (active_cfg),
    .cfg_valid     (cfg_valid),
    .cfg_err       (cfg_err),
    .cfg_state     (cfg_state)
  );

  for (genvar i = 0; i < NUM_IO; i++) begin : g_ch
    logic dir, ireg, oreg;
    logic s, x, o;
    logic out_q, in_q;

    assign dir  = active_cfg[i*CFG_W + CFG_DIR];
    assign ireg = active_cfg[i*CFG_W + CFG_IREG];
    assign oreg = active_cfg[i*CFG_W + CFG_OREG];

`ifdef IO_INPUT_SYNC_EN
    logic sync1, sync2;
    always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= io.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN[i];
        sync2 <= sync1;
      end
    end
    assign s = sync2;
`else
    assign s = io.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN[i];
`endif

    // Data flops run regardless of direction; isolation only gates the outputs.
    always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
        out_q <= 1'b0;
        in_q  <= 1'b0;
      end else begin
        out_q <= io.io_outpad[i];
        in_q  <= s;
      end
    end

    assign o = oreg ? out_q : io.io_outpad[i];
    assign x = ireg ? in_q : s;

    assign dir_v[i] = dir & IO_ISOL_N;
    assign out_v[i] = (dir & IO_ISOL_N) ? o : 1'b0;
    assign in_v[i]  = (!dir & IO_ISOL_N) ? x : 1'b0;
  end

  assign io.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR = dir_v;
  assign io.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT = out_v;
  assign io.io_inpad                            = in_v;
endmodule

// File: tb/tb_logical_tile_io_array_cfg.sv
// Self-checking bench for the embedded-IO logical tile: config loads, pad paths, isolation, chain.
module tb_logical_tile_io_array_cfg;
  import io_tile_pkg::*;

  localparam int NUM_IO = 4;
  localparam int CL     = NUM_IO * CFG_W;
`ifdef IO_INPUT_SYNC_EN
  localparam int IN_LAT = 2;
`else
  localparam int IN_LAT = 0;
`endif

  typedef struct {
    logic [3:0] soc_in;
    logic [3:0] outpad;
    logic       isol_n;
    logic [3:0] exp_inpad;
    logic [3:0] exp_out;
    logic [3:0] exp_dir;
  } vec_t;

  // clock / reset
  logic       prog_clk = 1'b0;
  logic       prog_reset;
  logic       IO_ISOL_N;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       ccff_tail;
  logic       cfg_valid;
  logic       cfg_err;
  cfg_state_t cfg_state;

  always #5 prog_clk = ~prog_clk;

  logical_tile_io_array_cfg_if #(.NUM_IO(NUM_IO)) bus ();

  logical_tile_io_array_cfg #(.NUM_IO(NUM_IO)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .IO_ISOL_N     (IO_ISOL_N),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .cfg_valid     (cfg_valid),
    .cfg_err       (cfg_err),
    .cfg_state     (cfg_state),
    .io            (bus)
  );

  // scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] soc_in, input logic [3:0] outpad, input logic isol_n);
    bus.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN = soc_in;
    bus.io_outpad                          = outpad;
    IO_ISOL_N                              = isol_n;
  endtask

  task automatic apply_vec(input string name, input vec_t v);
    drive(v.soc_in, v.outpad, v.isol_n);
    exp_q.push_back({20'd0, v.exp_inpad, v.exp_out, v.exp_dir});
    repeat (IN_LAT + 2) tick();
    check(name, {20'd0, bus.io_inpad, bus.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT,
                 bus.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR}, exp_q.pop_front());
  endtask

  // First bit shifted lands in the MSB (ch NUM_IO-1 OREG).
  task automatic shift_bits(input logic [CL-1:0] bits, input int n);
    for (int k = CL - 1; k >= CL - n; k--) begin
      ccff_head     = bits[k];
      ccff_shift_en = 1'b1;
      tick();
    end
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
  endtask

  task automatic load_cfg(input string name, input logic [CL-1:0] bits);
    shift_bits(bits, CL);
    tick();
    check({name, "_commit_state"}, 32'(cfg_state), 32'(COMMIT));
    tick();
    check({name, "_valid"}, 32'(cfg_valid), 32'd1);
    check({name, "_err"}, 32'(cfg_err), 32'd0);
    check({name, "_idle"}, 32'(cfg_state), 32'(IDLE));
  endtask

  function automatic vec_t model_405(input logic [3:0] soc_in, input logic [3:0] outpad,
                                     input logic isol_n);
    vec_t v;
    v.soc_in    = soc_in;
    v.outpad    = outpad;
    v.isol_n    = isol_n;
    v.exp_dir   = isol_n ? 4'b0001 : 4'b0000;
    v.exp_out   = isol_n ? {3'b000, outpad[0]} : 4'b0000;
    v.exp_inpad = isol_n ? (soc_in & 4'b1110) : 4'b0000;
    return v;
  endfunction

  vec_t        tbl[6];
  logic [23:0] stream;
  logic [CL-1:0] old_shadow;

  initial begin
    // cfg 12'h405: ch0 output+OREG, ch3 input+IREG, ch1/ch2 plain inputs
    tbl[0] = '{4'b1111, 4'b1111, 1'b1, 4'b1110, 4'b0001, 4'b0001};
    tbl[1] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0001, 4'b0001};
    tbl[2] = '{4'b1010, 4'b0000, 1'b1, 4'b1010, 4'b0000, 4'b0001};
    tbl[3] = '{4'b0101, 4'b1110, 1'b1, 4'b0100, 4'b0000, 4'b0001};
    tbl[4] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[5] = '{4'b0110, 4'b0001, 1'b1, 4'b0110, 4'b0001, 4'b0001};

    prog_reset    = 1'b1;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    drive(4'b1010, 4'b1111, 1'b1);
    repeat (2) tick();
    prog_reset = 1'b0;

    // reset state
    check("rst_dir", 32'(bus.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR), 32'h0);
    check("rst_out", 32'(bus.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT), 32'h0);
    check("rst_valid", 32'(cfg_valid), 32'h0);
    check("rst_err", 32'(cfg_err), 32'h0);
    check("rst_tail", 32'(ccff_tail), 32'h0);
    check("rst_state", 32'(cfg_state), 32'(IDLE));
    repeat (IN_LAT) tick();
    check("rst_inpad", 32'(bus.io_inpad), 32'b1010);

    // ch0 DIR=1 OREG=1, output registered by one cycle
    load_cfg("cfg005", 12'h005);
    drive(4'b0000, 4'b0000, 1'b1);
    repeat (2) tick();
    bus.io_outpad = 4'b0001;
    #1;
    check("oreg_before", 32'(bus.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT), 32'b0000);
    tick();
    check("oreg_after", 32'(bus.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT), 32'b0001);

    // short load flags error and keeps the old active config
    shift_bits(12'h008, CL - 1);
    tick();
    check("short_err", 32'(cfg_err), 32'd1);
    check("short_state", 32'(cfg_state), 32'(IDLE));
    check("short_keep_dir", 32'(bus.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR), 32'b0001);
    load_cfg("cfg008", 12'h008);

    // isolation: ch1 output, others input
    apply_vec("isol_on",  '{4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000});
    apply_vec("isol_off", '{4'b1111, 4'b1111, 1'b1, 4'b1101, 4'b0010, 4'b0010});

    // table vectors under cfg 12'h405
    load_cfg("cfg405", 12'h405);
    for (int i = 0; i < 6; i++) apply_vec($sformatf("tbl%0d", i), tbl[i]);
    for (int i = 0; i < 8; i++)
      apply_vec($sformatf("rnd%0d", i),
                model_405(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1))));

    // input step on IREG channel: latency IN_LAT+1
    drive(4'b0000, 4'b0000, 1'b1);
    repeat (IN_LAT + 2) tick();
    bus.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN = 4'b1000;
    for (int c = 0; c <= IN_LAT + 1; c++) begin
      if (c > 0) tick();
      #1;
      check($sformatf("ireg_lat_c%0d", c), 32'(bus.io_inpad[3]), 32'(c == IN_LAT + 1));
    end

    // 24 bits through the chain: tail replays the shadow then the stream
    old_shadow = 12'h405;
    stream     = 24'($urandom);
    exp_q.delete();
    for (int k = CL - 1; k >= 0; k--) exp_q.push_back(32'(old_shadow[k]));
    check("chain_j0", 32'(ccff_tail), exp_q.pop_front());
    for (int j = 0; j < 24; j++) begin
      exp_q.push_back(32'(stream[j]));
      ccff_head     = stream[j];
      ccff_shift_en = 1'b1;
      tick();
      check($sformatf("chain_j%0d", j + 1), 32'(ccff_tail), exp_q.pop_front());
    end
    exp_q.delete();
    ccff_shift_en = 1'b0;
    tick();
    check("long_err", 32'(cfg_err), 32'd1);
    check("long_keep_dir", 32'(bus.gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR), 32'b0001);

    // reset in the middle of a load
    shift_bits(12'h008, 6);
    prog_reset    = 1'b1;
    ccff_shift_en = 1'b1;
    tick();
    prog_reset    = 1'b0;
    ccff_shift_en = 1'b0;
    check("midrst_state", 32'(cfg_state), 32'(IDLE));
    check("midrst_valid", 32'(cfg_valid), 32'd0);
    check("midrst_err", 32'(cfg_err), 32'd0);
    check("midrst_tail", 32'(ccff_tail), 32'd0);
    apply_vec("midrst_pads", '{4'b1010, 4'b1111, 1'b1, 4'b1010, 4'b0000, 4'b0000});

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
